cpu_run_ctrl: RTL and testbench

- Sequencer for the pipelined RISC-V core, driving the core's external memory ports and run control.
- One session: stream a program into instruction memory, stream initial data into data memory, release the core and run it for a programmed number of cycles, then stream a data-memory region back out.
- Sits directly above the cpu top level; replaces testbench-driven loading.

---
 rtl/cpu_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Session sequencer for the pipelined core: loads imem/dmem over a valid/ready stream,
// runs the core for a fixed cycle count, then streams a dmem region back out.
module cpu_run_ctrl #(
    parameter int unsigned IMEM_WORDS = 128,
    parameter int unsigned DMEM_WORDS = 128,
    parameter int unsigned LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] imem_len,
    input  logic [LEN_W-1:0] dmem_len,
    input  logic [31:0]      run_cycles,
    input  logic [LEN_W-1:0] dump_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             cpu_arst_n,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle, StLoadI, StLoadD, StRun, StDumpRd, StDumpWait, StDumpOut, StDone
    } state_e;

    localparam logic [LEN_W-1:0] ImemMax = LEN_W'(IMEM_WORDS);
    localparam logic [LEN_W-1:0] DmemMax = LEN_W'(DMEM_WORDS);
    localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] idx_q, ilen_q, dlen_q, plen_q;
    logic [31:0]      cnt_q, run_q;
    logic [63:0]      out_data_q;
    logic             cpu_arst_n_q, cpu_enable_q;
    logic             last_i, last_d, last_run, last_dump;
    logic [63:0]      addr_w4, addr_w8;

    // First phase with nonzero length, in session order.
    function automatic state_e first_phase(input logic i_nz, input logic d_nz,
                                           input logic r_nz, input logic p_nz);
        if (i_nz)      return StLoadI;
        else if (d_nz) return StLoadD;
        else if (r_nz) return StRun;
        else if (p_nz) return StDumpRd;
        else           return StDone;
    endfunction

    assign last_i    = (idx_q == ilen_q - LenOne);
    assign last_d    = (idx_q == dlen_q - LenOne);
    assign last_dump = (idx_q == plen_q - LenOne);
    assign last_run  = (cnt_q == run_q - 32'd1);
    assign addr_w4   = {{(62 - LEN_W){1'b0}}, idx_q, 2'b00};
    assign addr_w8   = {{(61 - LEN_W){1'b0}}, idx_q, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start) state_d = first_phase(imem_len != '0, dmem_len != '0,
                                                         run_cycles != '0, dump_len != '0);
            StLoadI:    if (in_valid && last_i)
                            state_d = first_phase(1'b0, dlen_q != '0, run_q != '0, plen_q != '0);
            StLoadD:    if (in_valid && last_d)
                            state_d = first_phase(1'b0, 1'b0, run_q != '0, plen_q != '0);
            StRun:      if (last_run) state_d = (plen_q != '0) ? StDumpRd : StDone;
            StDumpRd:   state_d = StDumpWait;
            StDumpWait: state_d = StDumpOut;
            StDumpOut:  if (out_ready) state_d = last_dump ? StDone : StDumpRd;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            ilen_q       <= '0;
            dlen_q       <= '0;
            plen_q       <= '0;
            run_q        <= '0;
            out_data_q   <= '0;
            cpu_arst_n_q <= 1'b0;
            cpu_enable_q <= 1'b0;
        end else begin
            // Core controls follow the upcoming state so they line up with it exactly.
            cpu_enable_q <= (state_d == StRun);
            cpu_arst_n_q <= (state_d inside {StRun, StDumpRd, StDumpWait, StDumpOut, StDone});
            case (state_q)
                StIdle: if (start) begin
                    idx_q  <= '0;
                    cnt_q  <= '0;
                    ilen_q <= (imem_len > ImemMax) ? ImemMax : imem_len;
                    dlen_q <= (dmem_len > DmemMax) ? DmemMax : dmem_len;
                    plen_q <= (dump_len > DmemMax) ? DmemMax : dump_len;
                    run_q  <= run_cycles;
                end
                StLoadI:    if (in_valid) idx_q <= last_i ? '0 : idx_q + LenOne;
                StLoadD:    if (in_valid) idx_q <= last_d ? '0 : idx_q + LenOne;
                StRun:      cnt_q <= last_run ? '0 : cnt_q + 32'd1;
                StDumpWait: out_data_q <= rdata_ext_2;
                StDumpOut:  if (out_ready) idx_q <= idx_q + LenOne;
                StDone:     idx_q <= '0;
                default:    ;
            endcase
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        wen_ext     = 1'b0;
        addr_ext    = '0;
        wdata_ext   = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = '0;
        wdata_ext_2 = '0;
        done        = 1'b0;
        case (state_q)
            StLoadI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wen_ext   = 1'b1;
                    addr_ext  = addr_w4;
                    wdata_ext = in_data[31:0];
                end
            end
            StLoadD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wen_ext_2   = 1'b1;
                    addr_ext_2  = addr_w8;
                    wdata_ext_2 = in_data;
                end
            end
            StDumpRd: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = addr_w8;
            end
            StDumpOut: out_valid = 1'b1;
            StDone:    done = 1'b1;
            default:   ;
        endcase
    end

    assign ren_ext    = 1'b0;
    assign busy       = (state_q != StIdle);
    assign out_data   = out_data_q;
    assign cpu_arst_n = cpu_arst_n_q;
    assign cpu_enable = cpu_enable_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: the bench models both memories and scoreboards every
// ext write and every dumped word against queues filled when stimulus is driven.
module tb_cpu_run_ctrl;

    localparam int unsigned LEN_W = 8;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] imem_len = '0, dmem_len = '0, dump_len = '0;
    logic [31:0]      run_cycles = '0;
    logic             in_valid = 1'b0, in_ready;
    logic [63:0]      in_data = '0;
    logic             out_valid, out_ready = 1'b1;
    logic [63:0]      out_data;
    logic             cpu_arst_n, cpu_enable;
    logic [63:0]      addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0]      wdata_ext;
    logic             busy, done;

    int n_cmp = 0, n_fail = 0;
    int wen_cnt = 0, wen2_cnt = 0, ren2_cnt = 0, en_cnt = 0, done_cnt = 0;
    wr_t         iexp[$], dexp[$];
    logic [63:0] oexp[$];
    wr_t         mon_w;
    logic [63:0] mon_o;
    logic [63:0] dm [0:127];

    cpu_run_ctrl #(.IMEM_WORDS(128), .DMEM_WORDS(128), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles), .dump_len(dump_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Data memory with one-cycle read latency.
    always @(posedge clk) begin
        if (wen_ext_2) dm[addr_ext_2[9:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dm[addr_ext_2[9:3]];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wen_ext) begin
                wen_cnt++;
                if (iexp.size() == 0) check("imem_unexpected_write", 64'd1, 64'd0);
                else begin
                    mon_w = iexp.pop_front();
                    check("imem_addr", addr_ext, mon_w.addr);
                    check("imem_data", {32'b0, wdata_ext}, mon_w.data);
                end
            end
            if (wen_ext_2) begin
                wen2_cnt++;
                if (dexp.size() == 0) check("dmem_unexpected_write", 64'd1, 64'd0);
                else begin
                    mon_w = dexp.pop_front();
                    check("dmem_addr", addr_ext_2, mon_w.addr);
                    check("dmem_data", wdata_ext_2, mon_w.data);
                end
            end
            if (out_valid && out_ready) begin
                if (oexp.size() == 0) check("dump_unexpected", 64'd1, 64'd0);
                else begin
                    mon_o = oexp.pop_front();
                    check("dump_data", out_data, mon_o);
                end
            end
            if (ren_ext_2) ren2_cnt++;
            if (ren_ext) check("ren_ext_zero", {63'b0, ren_ext}, 64'd0);
            if (cpu_enable) begin
                en_cnt++;
                check("arst_in_run", {63'b0, cpu_arst_n}, 64'd1);
            end
            if (in_ready) check("arst_in_load", {63'b0, cpu_arst_n}, 64'd0);
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int il, input int dl, input int rc, input int pl);
        imem_len   = LEN_W'(il);
        dmem_len   = LEN_W'(dl);
        run_cycles = 32'(rc);
        dump_len   = LEN_W'(pl);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("idle_timeout", {63'b0, busy}, 64'd0);
    endtask

    task automatic clear_counts();
        wen_cnt = 0; wen2_cnt = 0; ren2_cnt = 0; en_cnt = 0; done_cnt = 0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_arst_n", {63'b0, cpu_arst_n}, 64'd0);
        check("rst_enable", {63'b0, cpu_enable}, 64'd0);
        check("rst_wens", {62'b0, wen_ext, wen_ext_2}, 64'd0);
        rst = 1'b0;
        tick();

        // Reset mid-LOAD_D after 2 of 4 words, then reload from address 0
        kick(0, 4, 0, 0);
        dexp.push_back('{64'd0, 64'h11});
        dexp.push_back('{64'd8, 64'h22});
        send(64'h11);
        send(64'h22);
        rst = 1'b1;
        tick();
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_arst_n", {63'b0, cpu_arst_n}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        clear_counts();
        kick(0, 4, 0, 0);
        for (int i = 0; i < 4; i++) dexp.push_back('{64'(i * 8), 64'h100 + 64'(i)});
        for (int i = 0; i < 4; i++) send(64'h100 + 64'(i));
        wait_idle(20);
        check("reload_wen2_cnt", 64'(wen2_cnt), 64'd4);
        check("reload_dexp_empty", 64'(dexp.size()), 64'd0);

        // Full session: 3 instr, 2 data, 5 run cycles, dump 2
        clear_counts();
        iexp.push_back('{64'd0, 64'h00500093});
        iexp.push_back('{64'd4, 64'h00100113});
        iexp.push_back('{64'd8, 64'h002081B3});
        dexp.push_back('{64'd0, 64'hA});
        dexp.push_back('{64'd8, 64'hB});
        oexp.push_back(64'hA);
        oexp.push_back(64'hB);
        kick(3, 2, 5, 2);
        send({32'hDEADBEEF, 32'h00500093});
        send({32'hCAFEF00D, 32'h00100113});
        send({32'h12345678, 32'h002081B3});
        send(64'hA);
        send(64'hB);
        wait_idle(100);
        check("full_enable_cycles", 64'(en_cnt), 64'd5);
        check("full_done_pulses", 64'(done_cnt), 64'd1);
        check("full_ren2_cnt", 64'(ren2_cnt), 64'd2);
        check("full_queues_empty", 64'(iexp.size() + dexp.size() + oexp.size()), 64'd0);

        // in_valid toggling during LOAD_I keeps addresses contiguous
        clear_counts();
        for (int i = 0; i < 3; i++) iexp.push_back('{64'(i * 4), 64'h3000 + 64'(i)});
        kick(3, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send(64'h3000 + 64'(i));
            tick();
        end
        wait_idle(20);
        check("toggle_wen_cnt", 64'(wen_cnt), 64'd3);
        check("toggle_iexp_empty", 64'(iexp.size()), 64'd0);

        // Back-pressure on the dump stream
        clear_counts();
        oexp.push_back(64'hA);
        oexp.push_back(64'hB);
        out_ready = 1'b0;
        kick(0, 0, 0, 2);
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_out_valid", {63'b0, out_valid}, 64'd1);
            check("bp_out_data", out_data, 64'hA);
            check("bp_ren2_cnt", 64'(ren2_cnt), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(20);
        check("bp_ren2_total", 64'(ren2_cnt), 64'd2);
        check("bp_oexp_empty", 64'(oexp.size()), 64'd0);

        // All-zero session: IDLE -> DONE -> IDLE
        clear_counts();
        kick(0, 0, 0, 0);
        check("zero_done", {63'b0, done}, 64'd1);
        check("zero_busy", {63'b0, busy}, 64'd1);
        tick();
        check("zero_done_drop", {63'b0, done}, 64'd0);
        check("zero_idle", {63'b0, busy}, 64'd0);
        check("zero_no_enables", 64'(wen_cnt + wen2_cnt + ren2_cnt + en_cnt), 64'd0);

        // imem_len saturation at 128 words; start during RUN is ignored
        clear_counts();
        for (int i = 0; i < 128; i++) iexp.push_back('{64'(i * 4), 64'h10000000 + 64'(i)});
        kick(200, 0, 4, 0);
        for (int i = 0; i < 128; i++) send({32'hFFFF0000 ^ 32'(i), 32'h10000000 + 32'(i)});
        check("sat_in_run", {63'b0, cpu_enable}, 64'd1);
        imem_len = 8'd5;
        start    = 1'b1;
        in_valid = 1'b1;
        check("sat_no_ready_in_run", {63'b0, in_ready}, 64'd0);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        wait_idle(20);
        check("sat_wen_cnt", 64'(wen_cnt), 64'd128);
        check("sat_iexp_empty", 64'(iexp.size()), 64'd0);
        check("sat_enable_cycles", 64'(en_cnt), 64'd4);
        check("sat_done_pulses", 64'(done_cnt), 64'd1);
        tick(); tick();
        check("sat_start_ignored", {63'b0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
